// File: rtl/mem_stage_pkg.sv
// Shared pipeline constants: inter-stage bus widths and field positions.
package mem_stage_pkg;

  // es_to_ms_bus: {no_dest[71], res_from_mem[70], gr_we[69], dest[68:64],
  //                alu_result[63:32], pc[31:0]}
  localparam int unsigned ES_TO_MS_BUS_WD = 72;
  // ms_to_ws_bus: {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
  localparam int unsigned MS_TO_WS_BUS_WD = 70;
  // ms_to_ds_bus: {fwd_ok[38], no_dest[37], dest[36:32], final_result[31:0]}
  localparam int unsigned MS_TO_DS_BUS_WD = 39;

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, merges load data from the
// data SRAM, and keeps load results stable across writeback stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic [31:0]                data_sram_rdata
);

  logic                       ms_valid;
  logic                       ms_first;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic [31:0]                rdata_buf;

  logic        no_dest;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_first <= 1'b0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      // High only for the cycle right after an accept, even when stalled.
      ms_first <= es_to_ms_valid && ms_allowin;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      es_to_ms_bus_r <= es_to_ms_bus;
    end
  end

  // The SRAM only presents data in the first cycle; keep a copy for stalls.
  always_ff @(posedge clk) begin
    if (ms_valid && ms_first && res_from_mem) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign {no_dest, res_from_mem, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;

  assign load_data    = ms_first ? data_sram_rdata : rdata_buf;
  assign final_result = res_from_mem ? load_data : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  assign ms_to_ds_bus = {ms_valid,
                         ms_valid ? no_dest : 1'b1,
                         ms_valid ? dest : 5'd0,
                         final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;
  logic [31:0]                data_sram_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_to_ds_bus    (ms_to_ds_bus),
    .data_sram_rdata (data_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mk(input logic nd, input logic rfm, input logic we,
                                     input logic [4:0] d, input logic [31:0] alu,
                                     input logic [31:0] p);
    return {nd, rfm, we, d, alu, p};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Idle after reset
    chk("rst_allowin", 72'(ms_allowin), 72'd1);
    chk("rst_ws_valid", 72'(ms_to_ws_valid), 72'd0);
    chk("rst_ds_dest", 72'(ms_to_ds_bus[36:32]), 72'd0);
    chk("rst_ds_nodest", 72'(ms_to_ds_bus[37]), 72'd1);
    chk("rst_ds_fwd", 72'(ms_to_ds_bus[38]), 72'd0);

    // Plain ALU op, one-cycle latency
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000);
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = mk(1'b1, 1'b1, 1'b0, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    chk("alu_valid", 72'(ms_to_ws_valid), 72'd1);
    chk("alu_ws_bus", 72'(ms_to_ws_bus), 72'({1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000}));
    chk("alu_ds_bus", 72'(ms_to_ds_bus), 72'({1'b1, 1'b0, 5'd5, 32'h1234_5678}));
    tick();
    chk("alu_bubble_valid", 72'(ms_to_ws_valid), 72'd0);
    chk("alu_bubble_allowin", 72'(ms_allowin), 72'd1);
    chk("alu_bubble_ds_dest", 72'(ms_to_ds_bus[37:32]), 72'({1'b1, 5'd0}));

    // Load with a 3-cycle writeback stall; SRAM data present in first cycle only
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_0040, 32'h0000_2000);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall_c1_result", 72'(ms_to_ws_bus[63:32]), 72'(32'hDEAD_BEEF));
    chk("stall_c1_allowin", 72'(ms_allowin), 72'd0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      data_sram_rdata = 32'h0;
      #1;
      chk($sformatf("stall_c%0d_result", i), 72'(ms_to_ws_bus[63:32]), 72'(32'hDEAD_BEEF));
      chk($sformatf("stall_c%0d_allowin", i), 72'(ms_allowin), 72'd0);
      chk($sformatf("stall_c%0d_valid", i), 72'(ms_to_ws_valid), 72'd1);
    end
    tick();
    ws_allowin = 1'b1;
    #1;
    chk("stall_c4_result", 72'(ms_to_ws_bus[63:32]), 72'(32'hDEAD_BEEF));
    chk("stall_c4_allowin", 72'(ms_allowin), 72'd1);
    tick();
    chk("stall_drained", 72'(ms_to_ws_valid), 72'd0);

    // Back-to-back loads, then a load followed directly by an ALU op
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0100, 32'h0000_3000);
    tick();
    data_sram_rdata = 32'hAAAA_0001;
    es_to_ms_bus = mk(1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0104, 32'h0000_3004);
    #1;
    chk("b2b_a_result", 72'(ms_to_ws_bus[63:32]), 72'(32'hAAAA_0001));
    chk("b2b_a_dest", 72'(ms_to_ws_bus[68:64]), 72'd8);
    tick();
    data_sram_rdata = 32'hBBBB_0002;
    es_to_ms_bus = mk(1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_0108, 32'h0000_3008);
    #1;
    chk("b2b_b_result", 72'(ms_to_ws_bus[63:32]), 72'(32'hBBBB_0002));
    chk("b2b_b_pc", 72'(ms_to_ws_bus[31:0]), 72'(32'h0000_3004));
    tick();
    data_sram_rdata = 32'hAAAA_0001;
    es_to_ms_bus = mk(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0007, 32'h0000_300C);
    #1;
    chk("ld_then_alu_ld_result", 72'(ms_to_ws_bus[63:32]), 72'(32'hAAAA_0001));
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h5555_5555;
    #1;
    chk("ld_then_alu_result", 72'(ms_to_ws_bus[63:32]), 72'(32'h0000_0007));
    chk("ld_then_alu_dest", 72'(ms_to_ws_bus[68:64]), 72'd9);
    tick();
    chk("ld_then_alu_buf", 72'(dut.rdata_buf), 72'(32'hAAAA_0001));
    chk("ld_then_alu_drained", 72'(ms_to_ws_valid), 72'd0);

    // Reset while a load is stalled
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_0200, 32'h0000_4000);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall_valid", 72'(ms_to_ws_valid), 72'd0);
    chk("rst_stall_allowin", 72'(ms_allowin), 72'd1);
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_5000);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("post_rst_first", 72'(dut.ms_first), 72'd1);
    chk("post_rst_ws_bus", 72'(ms_to_ws_bus), 72'({1'b1, 5'd5, 32'h1234_5678, 32'h0000_5000}));
    tick();
    chk("post_rst_drained", 72'(ms_to_ws_valid), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
